// File: rtl/order_tx_encoder.sv
// rtl/order_tx_encoder.sv - decision FIFO plus 18-byte order frame serializer
//
// Buffers single-cycle trading decisions and emits each one as an 18-byte
// frame: type, order_id (8B), price (4B), volume (4B), all MSB first, then an
// XOR checksum of the 17 preceding bytes.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   decision_valid           one-cycle pulse, decision fields valid
//   decision_type            side byte, passed through unchecked
//   d_order_id/d_price/d_volume  decision fields, captured on push
//   tx_data/tx_valid/tx_ready    outbound byte stream with handshake
//   busy                     high while a frame is being sent
//   fifo_level               queued entries, excluding the frame in flight
//   drop_count               saturating count of decisions lost to a full FIFO
module order_tx_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               decision_valid,
  input  logic [7:0]                         decision_type,
  input  logic [63:0]                        d_order_id,
  input  logic [31:0]                        d_price,
  input  logic [31:0]                        d_volume,
  output logic [7:0]                         tx_data,
  output logic                               tx_valid,
  input  logic                               tx_ready,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic [CNT_W-1:0]                   drop_count
);

  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
  localparam logic [4:0] LAST_IDX = 5'd17;
  // Handshake on this index makes the checksum the next byte on the wire.
  localparam logic [4:0] CSUM_IDX = 5'd16;

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state;
  logic [135:0]  mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [135:0]  frame_sr;
  logic [4:0]    idx;
  logic [7:0]    csum;
  logic          pop;
  logic          push;

  // The serializer only pulls a new entry while idle, so a full FIFO can
  // still take a push in the same cycle the head leaves for the frame.
  assign pop  = (state == IDLE) && (fifo_level != '0);
  assign push = decision_valid && ((fifo_level != FULL_LVL) || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      drop_count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {decision_type, d_order_id, d_price, d_volume};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: ;
      endcase
      if (decision_valid && !push && (drop_count != '1)) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      busy     <= 1'b0;
      idx      <= '0;
      csum     <= '0;
      frame_sr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            // Byte 0 goes straight to tx_data; frame_sr keeps it at the top
            // so the next byte is always frame_sr[127:120].
            frame_sr <= mem[rd_ptr];
            tx_data  <= mem[rd_ptr][135:128];
            tx_valid <= 1'b1;
            busy     <= 1'b1;
            idx      <= '0;
            csum     <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          // tx_valid is held high throughout SEND, so tx_ready alone marks
          // a handshake; without one every output holds.
          if (tx_ready) begin
            csum <= csum ^ tx_data;
            if (idx == LAST_IDX) begin
              tx_valid <= 1'b0;
              busy     <= 1'b0;
              state    <= IDLE;
            end else begin
              idx      <= idx + 1'b1;
              frame_sr <= {frame_sr[127:0], 8'h00};
              tx_data  <= (idx == CSUM_IDX) ? (csum ^ tx_data) : frame_sr[127:120];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_order_tx_encoder.sv
// tb/tb_order_tx_encoder.sv - randomized self-checking bench for order_tx_encoder
module tb_order_tx_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        decision_valid;
  logic [7:0]  decision_type;
  logic [63:0] d_order_id;
  logic [31:0] d_price;
  logic [31:0] d_volume;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        busy;
  logic [2:0]  fifo_level;
  logic [15:0] drop_count;

  logic [7:0]  s_tx_data;
  logic        s_tx_valid;
  logic        s_busy;
  logic [2:0]  s_fifo_level;
  logic [1:0]  s_drop_count;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];

  int   ready_mode  = 0;
  logic ready_fixed = 1'b0;
  int   ready_phase = 0;

  always #5 clk = ~clk;

  order_tx_encoder #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .decision_valid(decision_valid), .decision_type(decision_type),
    .d_order_id(d_order_id), .d_price(d_price), .d_volume(d_volume),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .fifo_level(fifo_level), .drop_count(drop_count)
  );

  order_tx_encoder #(.FIFO_DEPTH(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .decision_valid(decision_valid), .decision_type(decision_type),
    .d_order_id(d_order_id), .d_price(d_price), .d_volume(d_volume),
    .tx_data(s_tx_data), .tx_valid(s_tx_valid), .tx_ready(tx_ready), .busy(s_busy),
    .fifo_level(s_fifo_level), .drop_count(s_drop_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference frame: the 17 payload bytes MSB first, then their XOR.
  task automatic expect_frame(input logic [7:0] t, input logic [63:0] id,
                              input logic [31:0] p, input logic [31:0] v);
    logic [135:0] f;
    logic [7:0]   b;
    logic [7:0]   x;
    f = {t, id, p, v};
    x = 8'h00;
    for (int i = 0; i < 17; i++) begin
      b = f[135 - 8*i -: 8];
      exp_q.push_back(b);
      x = x ^ b;
    end
    exp_q.push_back(x);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic scramble_fields();
    decision_type = 8'($urandom);
    d_order_id    = {$urandom, $urandom};
    d_price       = $urandom;
    d_volume      = $urandom;
  endtask

  task automatic pulse(input logic [7:0] t, input logic [63:0] id, input logic [31:0] p,
                       input logic [31:0] v, input bit accept);
    decision_valid = 1'b1;
    decision_type  = t;
    d_order_id     = id;
    d_price        = p;
    d_volume       = v;
    if (accept) expect_frame(t, id, p, v);
    idle(1);
    decision_valid = 1'b0;
    scramble_fields();
  endtask

  task automatic rand_pulse(input bit accept);
    pulse(8'($urandom), {$urandom, $urandom}, $urandom, $urandom, accept);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    idle(n);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tx_valid) && n < budget) begin
      idle(1);
      n++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  // Sink-side ready generator: fixed, 1,0,0,1 pattern, or random.
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0: tx_ready = ready_fixed;
        1: begin
          tx_ready    = (ready_phase == 0) || (ready_phase == 3);
          ready_phase = (ready_phase + 1) % 4;
        end
        default: tx_ready = (($urandom % 4) != 0);
      endcase
    end
  end

  // Monitor: every accepted byte must be the next reference byte, and a
  // stalled byte must hold.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", 64'(tx_valid), 64'd1);
          check("hold_data", 64'(tx_data), 64'(prev_data));
        end
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) check("unexpected_byte", 64'(tx_data), 64'h100);
          else check("byte", 64'(tx_data), 64'(exp_q.pop_front()));
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
      end
    end
  end

  initial begin
    int r1, gap, r2, stage, n;
    decision_valid = 1'b0;
    scramble_fields();
    rst = 1'b1;
    idle(3);
    check("rst_tx_valid", 64'(tx_valid), 64'd0);
    check("rst_tx_data", 64'(tx_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_drop", 64'(drop_count), 64'd0);
    rst = 1'b0;

    // Single frame with latency and length.
    ready_mode = 0; ready_fixed = 1'b1;
    idle(2);
    pulse(8'h42, 64'h0102030405060708, 32'h00001388, 32'h00000064, 1'b1);
    check("lat_n1_valid", 64'(tx_valid), 64'd0);
    idle(1);
    check("lat_n2_valid", 64'(tx_valid), 64'd1);
    check("lat_n2_byte0", 64'(tx_data), 64'h42);
    check("lat_n2_busy", 64'(busy), 64'd1);
    n = 0;
    while (tx_valid && n < 40) begin idle(1); n++; end
    check("frame_len", 64'(n), 64'd18);
    check("single_drained", 64'(exp_q.size()), 64'd0);
    check("single_busy_low", 64'(busy), 64'd0);
    check("single_drop", 64'(drop_count), 64'd0);

    // Backpressure with the 1,0,0,1 pattern.
    ready_mode = 1;
    pulse(8'h42, 64'h0102030405060708, 32'h00001388, 32'h00000064, 1'b1);
    wait_drain("bp_drain", 400);

    // Back-to-back pulses: 18 high, one low, 18 high.
    ready_mode = 0; ready_fixed = 1'b1;
    idle(3);
    rand_pulse(1'b1);
    rand_pulse(1'b1);
    r1 = 0; gap = 0; r2 = 0; stage = 0;
    for (int c = 0; c < 80; c++) begin
      case (stage)
        0: if (tx_valid) begin stage = 1; r1 = 1; end
        1: if (tx_valid) r1++; else begin stage = 2; gap = 1; end
        2: if (!tx_valid) gap++; else begin stage = 3; r2 = 1; end
        3: if (tx_valid) r2++; else stage = 4;
        default: ;
      endcase
      idle(1);
    end
    check("b2b_run1", 64'(r1), 64'd18);
    check("b2b_gap", 64'(gap), 64'd1);
    check("b2b_run2", 64'(r2), 64'd18);
    check("b2b_drained", 64'(exp_q.size()), 64'd0);

    // Random bursts of up to 5 decisions against random backpressure.
    ready_mode = 2;
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 1 + int'($urandom % 5); k++) begin
        rand_pulse(1'b1);
        idle(int'($urandom % 3));
      end
      wait_drain("rand_drain", 1500);
    end
    check("rand_drop", 64'(drop_count), 64'd0);

    // Overflow: one in flight, four queued, two dropped, five frames out.
    ready_mode = 0; ready_fixed = 1'b0;
    do_reset(1);
    for (int i = 0; i < 7; i++) begin
      rand_pulse(i < 5);
      idle(2);
    end
    check("ovf_busy", 64'(busy), 64'd1);
    check("ovf_level", 64'(fifo_level), 64'd4);
    check("ovf_drop", 64'(drop_count), 64'd2);
    ready_fixed = 1'b1;
    wait_drain("ovf_drain", 400);
    check("ovf_level_end", 64'(fifo_level), 64'd0);

    // Reset at byte 6 with two entries queued.
    idle(2);
    pulse(8'h42, 64'h0102030405060708, 32'h00001388, 32'h00000064, 1'b1);
    rand_pulse(1'b1);
    rand_pulse(1'b1);
    idle(5);
    check("pre_rst_byte6", 64'(tx_data), 64'h06);
    check("pre_rst_level", 64'(fifo_level), 64'd2);
    do_reset(1);
    check("post_rst_valid", 64'(tx_valid), 64'd0);
    check("post_rst_level", 64'(fifo_level), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);
    n = 0;
    for (int c = 0; c < 30; c++) begin
      if (tx_valid) n++;
      idle(1);
    end
    check("post_rst_quiet", 64'(n), 64'd0);
    rand_pulse(1'b1);
    wait_drain("post_rst_drain", 200);

    // Saturation: fill, then five more pulses.
    ready_fixed = 1'b0;
    do_reset(1);
    for (int i = 0; i < 10; i++) begin
      rand_pulse(i < 5);
      idle(1);
    end
    check("sat_level", 64'(fifo_level), 64'd4);
    check("sat_drop_w16", 64'(drop_count), 64'd5);
    check("sat_drop_w2", 64'(s_drop_count), 64'd3);
    ready_fixed = 1'b1;
    wait_drain("sat_drain", 400);
    check("sat_drop_w2_hold", 64'(s_drop_count), 64'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
